// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and defaults for the regfile writeback arbiter.
// Both the RTL and the testbench import this package.
package regfile_wb_arbiter_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int MAX_WAIT = 4;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic [0:0] {
    ALU_PRI = 1'b0,
    MEM_PRI = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between the ALU and load writeback paths,
// registers the winning write and exposes a forwarding compare for decode.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN     = regfile_wb_arbiter_pkg::XLEN,
  parameter int REG_AW   = regfile_wb_arbiter_pkg::REG_AW,
  parameter int MAX_WAIT = regfile_wb_arbiter_pkg::MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  output logic              mem_ready,
  output logic [REG_AW-1:0] rd_num,
  output logic [XLEN-1:0]   rd_data,
  output logic              reg_w,
  input  logic [REG_AW-1:0] rs1num,
  input  logic [REG_AW-1:0] rs2num,
  output logic              rs1_fwd,
  output logic              rs2_fwd,
  output logic [XLEN-1:0]   fwd_data
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST  = CW'(MAX_WAIT - 1);
  localparam logic [0:0]    ST_ALU_PRI = ALU_PRI;
  localparam logic [0:0]    ST_MEM_PRI = MEM_PRI;

  logic [0:0]    state;
  logic [CW-1:0] wait_cnt;
  logic          alu_grant;
  logic          mem_grant;
  logic          same_rd;

  // A matching non-zero destination means the load is older; it must land first.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    same_rd   = alu_valid && mem_valid && (alu_rd == mem_rd) && (mem_rd != '0);
    if (!rst) begin
      if (same_rd)
        mem_grant = 1'b1;
      else if (state == ST_MEM_PRI && mem_valid)
        mem_grant = 1'b1;
      else if (alu_valid)
        alu_grant = 1'b1;
      else if (mem_valid)
        mem_grant = 1'b1;
    end
  end

  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_ALU_PRI;
      wait_cnt <= '0;
    end else if (mem_grant) begin
      state    <= ST_ALU_PRI;
      wait_cnt <= '0;
    end else if (mem_valid) begin
      if (state == ST_ALU_PRI && wait_cnt == WAIT_LAST)
        state <= ST_MEM_PRI;
      if (wait_cnt != WAIT_LAST)
        wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Writes to x0 are consumed but never assert the regfile enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_w   <= 1'b0;
      rd_num  <= '0;
      rd_data <= '0;
    end else if (alu_grant) begin
      reg_w   <= (alu_rd != '0);
      rd_num  <= alu_rd;
      rd_data <= alu_data;
    end else if (mem_grant) begin
      reg_w   <= (mem_rd != '0);
      rd_num  <= mem_rd;
      rd_data <= mem_data;
    end else begin
      reg_w   <= 1'b0;
    end
  end

  assign rs1_fwd  = reg_w && (rd_num == rs1num) && (rs1num != '0);
  assign rs2_fwd  = reg_w && (rd_num == rs2num) && (rs2num != '0);
  assign fwd_data = rd_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by random
// traffic, all checked against a behavioural model of the grant and write rules.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [REG_AW-1:0] mem_rd;
  logic [XLEN-1:0]   mem_data;
  logic              mem_ready;
  logic [REG_AW-1:0] rd_num;
  logic [XLEN-1:0]   rd_data;
  logic              reg_w;
  logic [REG_AW-1:0] rs1num;
  logic [REG_AW-1:0] rs2num;
  logic              rs1_fwd;
  logic              rs2_fwd;
  logic [XLEN-1:0]   fwd_data;

  int testsRun    = 0;
  int testsFailed = 0;

  // Model: expected registered write, plus how many cycles in a row mem has lost.
  logic              expRegW;
  logic [REG_AW-1:0] expRdNum;
  logic [XLEN-1:0]   expRdData;
  logic              known;
  int                memLosses;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rd_num(rd_num), .rd_data(rd_data), .reg_w(reg_w),
    .rs1num(rs1num), .rs2num(rs2num), .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
    .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: inputs already driven; checks readies and forwarding mid-cycle,
  // then the registered write after the edge.
  task automatic applyStimulus(output logic aAcc, output logic mAcc,
                               output logic obsA, output logic obsM);
    logic expA;
    logic expM;
    @(negedge clk);
    expA = 1'b0;
    expM = 1'b0;
    if (!rst) begin
      if (alu_valid && mem_valid && alu_rd == mem_rd && alu_rd != 0) expM = 1'b1;
      else if (memLosses >= MAX_WAIT && mem_valid)                   expM = 1'b1;
      else if (alu_valid)                                            expA = 1'b1;
      else if (mem_valid)                                            expM = 1'b1;
    end
    obsA = alu_ready;
    obsM = mem_ready;
    checkOutput("alu_ready", alu_ready, expA);
    checkOutput("mem_ready", mem_ready, expM);
    checkOutput("rs1_fwd", rs1_fwd, expRegW && rs1num == expRdNum && rs1num != 0);
    checkOutput("rs2_fwd", rs2_fwd, expRegW && rs2num == expRdNum && rs2num != 0);
    if (known) checkOutput("fwd_data", fwd_data, expRdData);
    @(posedge clk);
    #1;
    if (rst) begin
      expRegW = 1'b0; expRdNum = '0; expRdData = '0; known = 1'b1; memLosses = 0;
    end else begin
      if (expA || expM) begin
        expRdNum  = expA ? alu_rd : mem_rd;
        expRdData = expA ? alu_data : mem_data;
        expRegW   = (expRdNum != 0);
        known     = expRegW;
      end else begin
        expRegW = 1'b0;
      end
      memLosses = (expM || !mem_valid) ? 0 : memLosses + 1;
    end
    checkOutput("reg_w", reg_w, expRegW);
    if (known) begin
      checkOutput("rd_num", rd_num, expRdNum);
      checkOutput("rd_data", rd_data, expRdData);
    end
    aAcc = expA;
    mAcc = expM;
  endtask

  task automatic setIdle();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    rs1num = '0; rs2num = '0;
  endtask

  initial begin
    logic    aAcc, mAcc, obsA, obsM;
    wb_req_t aReq, mReq;
    logic [XLEN-1:0] aData;

    rst = 1'b1;
    setIdle();
    @(posedge clk);
    #1;
    expRegW = 1'b0; expRdNum = '0; expRdData = '0; known = 1'b1; memLosses = 0;

    // Request during reset is dropped
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1111_2222;
    applyStimulus(aAcc, mAcc, obsA, obsM);
    checkOutput("reset_alu_ready", obsA, 1'b0);
    checkOutput("reset_reg_w", reg_w, 1'b0);
    checkOutput("reset_rd_num", rd_num, 5'd0);
    rst = 1'b0;

    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    applyStimulus(aAcc, mAcc, obsA, obsM);
    checkOutput("single_ready", obsA, 1'b1);
    checkOutput("single_reg_w", reg_w, 1'b1);
    checkOutput("single_rd_num", rd_num, 5'd5);
    checkOutput("single_rd_data", rd_data, 32'hDEAD_BEEF);
    setIdle();
    applyStimulus(aAcc, mAcc, obsA, obsM);
    checkOutput("single_idle_reg_w", reg_w, 1'b0);

    // Contention: mem wins only after MAX_WAIT losses
    alu_valid = 1'b1; alu_rd = 5'd3;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h7777_0000;
    aData = 32'h0000_0100;
    for (int i = 0; i < 6; i++) begin
      alu_data = aData;
      applyStimulus(aAcc, mAcc, obsA, obsM);
      checkOutput($sformatf("contend_alu_%0d", i), obsA, i != MAX_WAIT);
      checkOutput($sformatf("contend_mem_%0d", i), obsM, i == MAX_WAIT);
      if (aAcc) aData = aData + 1;
    end
    setIdle();
    applyStimulus(aAcc, mAcc, obsA, obsM);

    // Same destination: older load first, ALU value ends up final
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hAAAA_0009;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h5555_0009;
    applyStimulus(aAcc, mAcc, obsA, obsM);
    checkOutput("waw_mem_first", obsM, 1'b1);
    checkOutput("waw_mem_data", rd_data, 32'h5555_0009);
    mem_valid = 1'b0;
    applyStimulus(aAcc, mAcc, obsA, obsM);
    checkOutput("waw_alu_second", obsA, 1'b1);
    setIdle();
    applyStimulus(aAcc, mAcc, obsA, obsM);
    checkOutput("waw_final_data", rd_data, 32'hAAAA_0009);

    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hCAFE_F00D;
    applyStimulus(aAcc, mAcc, obsA, obsM);
    checkOutput("x0_ready", obsM, 1'b1);
    checkOutput("x0_reg_w", reg_w, 1'b0);
    setIdle();

    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h1234_5678;
    applyStimulus(aAcc, mAcc, obsA, obsM);
    alu_valid = 1'b0; rs1num = 5'd12; rs2num = 5'd0;
    #1;
    checkOutput("fwd_rs1", rs1_fwd, 1'b1);
    checkOutput("fwd_rs2", rs2_fwd, 1'b0);
    checkOutput("fwd_value", fwd_data, 32'h1234_5678);
    applyStimulus(aAcc, mAcc, obsA, obsM);

    // Random traffic: sources hold requests until accepted, small rd pool for collisions
    aReq = '0;
    mReq = '0;
    for (int c = 0; c < 600; c++) begin
      if (!aReq.valid && ($urandom % 3 != 0)) begin
        aReq.valid = 1'b1;
        aReq.rd    = ($urandom % 8 == 0) ? REG_AW'($urandom_range(0, 31)) : REG_AW'($urandom_range(0, 7));
        aReq.data  = $urandom;
      end
      if (!mReq.valid && ($urandom % 3 != 0)) begin
        mReq.valid = 1'b1;
        mReq.rd    = ($urandom % 8 == 0) ? REG_AW'($urandom_range(0, 31)) : REG_AW'($urandom_range(0, 7));
        mReq.data  = $urandom;
      end
      rst       = ($urandom % 64 == 0);
      alu_valid = aReq.valid; alu_rd = aReq.rd; alu_data = aReq.data;
      mem_valid = mReq.valid; mem_rd = mReq.rd; mem_data = mReq.data;
      rs1num    = ($urandom % 2 == 0) ? expRdNum : REG_AW'($urandom_range(0, 31));
      rs2num    = ($urandom % 2 == 0) ? expRdNum : REG_AW'($urandom_range(0, 31));
      applyStimulus(aAcc, mAcc, obsA, obsM);
      if (rst) begin
        aReq = '0;
        mReq = '0;
      end else begin
        if (aAcc) aReq.valid = 1'b0;
        if (mAcc) mReq.valid = 1'b0;
      end
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
